// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor: counter states,
// default PC width and the PC -> index/tag split used by lookup and update.
package branch_predictor_pkg;

    localparam int PC_WIDTH_DEF = 32;

    localparam logic [1:0] CTR_SNT   = 2'd0;
    localparam logic [1:0] CTR_WNT   = 2'd1;
    localparam logic [1:0] CTR_WT    = 2'd2;
    localparam logic [1:0] CTR_ST    = 2'd3;
    localparam logic [1:0] CTR_RESET = CTR_WNT;

    // Word-aligned PCs: bits [1:0] never take part in indexing or tagging.
    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_bits);
        return (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_bits);
        return pc >> (idx_bits + 2);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter step: counts up on taken, down otherwise,
// holding at ST and SNT; passes the value through when not enabled.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       en_i,
    input  logic       taken_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (en_i) begin
            if (taken_i) begin
                if (cnt_i != CTR_ST) begin
                    cnt_o = cnt_i + 2'd1;
                end
            end else if (cnt_i != CTR_SNT) begin
                cnt_o = cnt_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: tagged 2-bit counter table with targets,
// 1-cycle registered lookup, write-first update bypass and mispredict stats.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int PC_WIDTH   = PC_WIDTH_DEF,
    parameter int IDX_BITS   = 4,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetchValid,
    input  logic [PC_WIDTH-1:0]   fetchPc,
    output logic                  predictValid,
    output logic                  predictHit,
    output logic                  predictTaken,
    output logic [PC_WIDTH-1:0]   predictTarget,
    input  logic                  updateValid,
    input  logic                  updateIsBranch,
    input  logic [PC_WIDTH-1:0]   updatePc,
    input  logic                  updateTaken,
    input  logic [PC_WIDTH-1:0]   updateTarget,
    input  logic                  updatePredTaken,
    input  logic [PC_WIDTH-1:0]   updatePredTarget,
    output logic                  mispredict,
    output logic [STAT_WIDTH-1:0] lookupCount,
    output logic [STAT_WIDTH-1:0] mispredictCount
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = PC_WIDTH - IDX_BITS - 2;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    logic                valid_q  [ENTRIES];
    logic                valid_d  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_d    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];
    logic [PC_WIDTH-1:0] target_d [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [1:0]          ctr_d    [ENTRIES];

    logic [IDX_BITS-1:0] upd_idx;
    logic [IDX_BITS-1:0] fetch_idx;
    logic [TAG_W-1:0]    upd_tag;
    logic [TAG_W-1:0]    fetch_tag;
    logic                upd_hit;
    logic                upd_branch;
    logic [1:0]          ctr_step;
    logic                misp_event;
    logic                look_hit;

    logic                  pred_valid_q;
    logic                  pred_hit_q;
    logic                  pred_taken_q;
    logic [PC_WIDTH-1:0]   pred_target_q;
    logic                  misp_q;
    logic [STAT_WIDTH-1:0] lookup_cnt_q;
    logic [STAT_WIDTH-1:0] misp_cnt_q;

    assign upd_idx   = IDX_BITS'(pc_index(64'(updatePc), IDX_BITS));
    assign upd_tag   = TAG_W'(pc_tag(64'(updatePc), IDX_BITS));
    assign fetch_idx = IDX_BITS'(pc_index(64'(fetchPc), IDX_BITS));
    assign fetch_tag = TAG_W'(pc_tag(64'(fetchPc), IDX_BITS));

    assign upd_branch = updateValid & updateIsBranch;
    assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign misp_event = upd_branch &
                        ((updateTaken != updatePredTaken) |
                         (updateTaken & (updatePredTarget != updateTarget)));

    sat_counter2 u_sat_counter2 (
        .cnt_i   (ctr_q[upd_idx]),
        .en_i    (upd_branch & upd_hit),
        .taken_i (updateTaken),
        .cnt_o   (ctr_step)
    );

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (updateValid) begin
            if (updateIsBranch) begin
                if (upd_hit) begin
                    ctr_d[upd_idx] = ctr_step;
                    if (updateTaken) begin
                        target_d[upd_idx] = updateTarget;
                    end
                end else if (updateTaken) begin
                    valid_d[upd_idx]  = 1'b1;
                    tag_d[upd_idx]    = upd_tag;
                    target_d[upd_idx] = updateTarget;
                    ctr_d[upd_idx]    = CTR_WT;
                end
            end else if (upd_hit) begin
                valid_d[upd_idx] = 1'b0;
            end
        end
    end

    // Lookup reads the next-state table, so a same-cycle update is visible.
    assign look_hit = valid_d[fetch_idx] && (tag_d[fetch_idx] == fetch_tag);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            misp_q        <= 1'b0;
            lookup_cnt_q  <= '0;
            misp_cnt_q    <= '0;
        end else begin
            pred_valid_q  <= fetchValid;
            pred_hit_q    <= look_hit;
            pred_taken_q  <= look_hit & ctr_d[fetch_idx][1];
            pred_target_q <= look_hit ? target_d[fetch_idx] : '0;
            misp_q        <= misp_event;
            if (fetchValid && lookup_cnt_q != STAT_MAX) begin
                lookup_cnt_q <= lookup_cnt_q + STAT_WIDTH'(1);
            end
            if (misp_event && misp_cnt_q != STAT_MAX) begin
                misp_cnt_q <= misp_cnt_q + STAT_WIDTH'(1);
            end
        end
    end

    assign predictValid    = pred_valid_q;
    assign predictHit      = pred_hit_q;
    assign predictTaken    = pred_taken_q;
    assign predictTarget   = pred_target_q;
    assign mispredict      = misp_q;
    assign lookupCount     = lookup_cnt_q;
    assign mispredictCount = misp_cnt_q;

endmodule
